// File: rtl/uart_bus_arbiter_if.sv
// Register-port bus (req/gnt/rvalid) shared by the LSU, the second master and the UART.
// master drives the request side, slave returns grant and response.
interface uart_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing the UART register port between two masters, one transaction
// in flight at a time, with a response timeout that returns an error to the owner.
module uart_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  uart_bus_arbiter_if.slave   m0,
  uart_bus_arbiter_if.slave   m1,
  uart_bus_arbiter_if.master  dev,
  output logic                busy_o,
  output logic                timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_RESP} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q;
  logic                  owner_q;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [1:0]            err_q;
  logic                  timeout_q;

  logic                  sel;
  logic                  sel_req;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  hs;

  // On conflict the requester that did not win last time goes next.
  assign sel       = (m0.req && m1.req) ? ~last_grant_q : m1.req;
  assign sel_req   = sel ? m1.req   : m0.req;
  assign sel_addr  = sel ? m1.addr  : m0.addr;
  assign sel_wdata = sel ? m1.wdata : m0.wdata;

  assign dev.req   = (state_q == IDLE) && sel_req;
  assign dev.we    = sel ? m1.we : m0.we;
  assign dev.be    = sel ? m1.be : m0.be;
  assign dev.addr  = sel_addr;
  assign dev.wdata = sel_wdata;

  assign hs     = dev.req && dev.gnt;
  assign m0.gnt = hs && !sel;
  assign m1.gnt = hs && sel;

  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata_q[0];
  assign m1.rdata  = rdata_q[1];
  assign m0.err    = err_q[0];
  assign m1.err    = err_q[1];
  assign busy_o    = (state_q == WAIT_RESP);
  assign timeout_o = timeout_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (hs) state_d = WAIT_RESP;
      WAIT_RESP: if (dev.rvalid || (cnt_q == CNT_LAST)) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      rvalid_q     <= '0;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
      err_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      rvalid_q  <= '0;
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        if (hs) begin
          owner_q      <= sel;
          last_grant_q <= sel;
          cnt_q        <= '0;
        end
      end else if (dev.rvalid) begin
        // A real response beats a timeout landing in the same cycle.
        rvalid_q[owner_q] <= 1'b1;
        rdata_q[owner_q]  <= dev.rdata;
        err_q[owner_q]    <= dev.err;
      end else if (cnt_q == CNT_LAST) begin
        rvalid_q[owner_q] <= 1'b1;
        rdata_q[owner_q]  <= '0;
        err_q[owner_q]    <= 1'b1;
        timeout_q         <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Randomized bench: two requesters and a random device, checked every cycle against a
// transaction-level model (outstanding owner, age since grant, round-robin winner).
module tb_uart_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int NCYC = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, tmo;

  always #5 clk = ~clk;

  uart_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  uart_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  uart_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dev_bus ();

  uart_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .dev       (dev_bus),
    .busy_o    (busy),
    .timeout_o (tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester state
  bit          pend [2];
  logic        we_r [2];
  logic [3:0]  be_r [2];
  logic [31:0] addr_r [2];
  logic [31:0] wdata_r [2];

  // reference model
  bit          m_busy;
  int          m_owner;
  int          m_age;
  int          m_last;
  bit          e_rvalid [2];
  logic [31:0] e_rdata [2];
  bit          e_err [2];
  bit          e_to;

  task automatic model_reset();
    m_busy = 1'b0;
    m_owner = 0;
    m_age = 0;
    m_last = 1;
    e_to = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_rvalid[i] = 1'b0;
      e_rdata[i]  = '0;
      e_err[i]    = 1'b0;
    end
  endtask

  task automatic check_regs(input string ph);
    chk({ph, "busy"}, busy, m_busy);
    chk({ph, "timeout"}, tmo, e_to);
    chk({ph, "m0_rvalid"}, m0_bus.rvalid, e_rvalid[0]);
    chk({ph, "m1_rvalid"}, m1_bus.rvalid, e_rvalid[1]);
    chk({ph, "m0_rdata"}, m0_bus.rdata, e_rdata[0]);
    chk({ph, "m1_rdata"}, m1_bus.rdata, e_rdata[1]);
    chk({ph, "m0_err"}, m0_bus.err, e_err[0]);
    chk({ph, "m1_err"}, m1_bus.err, e_err[1]);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
        pend[i]    = 1'b1;
        we_r[i]    = 1'($urandom_range(1, 0));
        be_r[i]    = 4'($urandom_range(15, 0));
        addr_r[i]  = $urandom;
        wdata_r[i] = $urandom;
      end
    end
    m0_bus.req = pend[0]; m0_bus.we = we_r[0]; m0_bus.be = be_r[0];
    m0_bus.addr = addr_r[0]; m0_bus.wdata = wdata_r[0];
    m1_bus.req = pend[1]; m1_bus.we = we_r[1]; m1_bus.be = be_r[1];
    m1_bus.addr = addr_r[1]; m1_bus.wdata = wdata_r[1];
    dev_bus.gnt    = ($urandom_range(9, 0) < 7);
    dev_bus.rvalid = ($urandom_range(9, 0) < 3);
    dev_bus.rdata  = $urandom;
    dev_bus.err    = ($urandom_range(7, 0) == 0);
  endtask

  initial begin
    bit in_rst;
    int win;
    bit both, exp_dreq, hs;

    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; we_r[i] = 1'b0; be_r[i] = '0; addr_r[i] = '0; wdata_r[i] = '0;
    end
    m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.be = '0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.be = '0; m1_bus.addr = '0; m1_bus.wdata = '0;
    dev_bus.gnt = 1'b0; dev_bus.rvalid = 1'b0; dev_bus.rdata = '0; dev_bus.err = 1'b0;
    model_reset();
    #12;
    check_regs("reset_");
    in_rst = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (in_rst) begin
        rst_n = 1'b1;
        in_rst = 1'b0;
      end
      drive_inputs();
      #4;

      both = pend[0] && pend[1];
      win = both ? (1 - m_last) : (pend[1] ? 1 : 0);
      exp_dreq = !m_busy && (pend[0] || pend[1]);
      hs = exp_dreq && dev_bus.gnt;

      chk("dev_req", dev_bus.req, exp_dreq);
      chk("m0_gnt", m0_bus.gnt, hs && win == 0);
      chk("m1_gnt", m1_bus.gnt, hs && win == 1);
      if (exp_dreq) begin
        chk("dev_addr", dev_bus.addr, addr_r[win]);
        chk("dev_wdata", dev_bus.wdata, wdata_r[win]);
        chk("dev_we", dev_bus.we, we_r[win]);
        chk("dev_be", dev_bus.be, be_r[win]);
      end
      check_regs("");

      // expected state after the coming clock edge
      e_to = 1'b0;
      e_rvalid[0] = 1'b0;
      e_rvalid[1] = 1'b0;
      if (!m_busy) begin
        if (hs) begin
          m_busy = 1'b1;
          m_owner = win;
          m_last = win;
          m_age = 0;
          pend[win] = 1'b0;
        end
      end else begin
        m_age++;
        if (dev_bus.rvalid) begin
          e_rvalid[m_owner] = 1'b1;
          e_rdata[m_owner]  = dev_bus.rdata;
          e_err[m_owner]    = dev_bus.err;
          m_busy = 1'b0;
        end else if (m_age == TO) begin
          e_rvalid[m_owner] = 1'b1;
          e_rdata[m_owner]  = '0;
          e_err[m_owner]    = 1'b1;
          e_to = 1'b1;
          m_busy = 1'b0;
        end
      end

      if ((cyc % 400) == 399) begin
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("midrst_");
        in_rst = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
